v_lsu_agu: RTL and testbench
============================

# v_lsu_agu

Vector load/store address-generation and sequencing unit. Accepts one decoded vector memory instruction (unit-stride or strided, load or store) and walks elements 0..vl-1. Per element it computes the byte address, issues one memory request with a valid/grant handshake, steers byte lanes, and writes zero-extended load elements back to the vector register file. It sits between instruction decode / VRF read and the data memory port, upstream of load-data formatting.

## Interface
Parameters:
- MAX_VL, 32: maximum element count
- IDX_W, $clog2(MAX_VL)+1: width of vl and element indices

Ports:
- clk  in  1  clock, all state on rising edge
- nrst  in  1  reset, synchronous, active-high (nrst=1 resets)
- start  in  1  launch pulse; honoured only in IDLE
- ld_store_op  in  3  VLE=000, VLSE=010, VSE=011, VSSE=110
- vsew  in  3  000=8b, 001=16b, 010=32b
- vl  in  IDX_W  element count, 0..MAX_VL
- base_addr  in  32  byte address of element 0
- stride  in  32  signed byte stride (strided ops only)
- vs3_rdata  in  32  store element for index elem_idx, LSB-aligned
- elem_idx  out  IDX_W  current element index
- mem_req  out  1  request valid
- mem_we  out  1  1=store
- mem_addr  out  32  word address (bits[1:0]=0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-steered store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load word
- vrf_we  out  1  load element write strobe
- vrf_widx  out  IDX_W  write element index
- vrf_wdata  out  32  zero-extended element
- busy  out  1  high in REQ/WAIT
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle, coincident with done, on illegal op/vsew or misalignment

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: start=1 latches all inputs; vl=0 or illegal op/vsew -> DONE (err=1 if illegal), no requests; else REQ, elem_idx=0, addr=base_addr.
- Effective stride: 1<<vsew for VLE/VSE, stride for VLSE/VSSE. Address accumulated (addr += stride each element), 32-bit wrap, no multiplier.
- Misalignment (16b with addr[0]=1; 32b with addr[1:0]!=0) detected on entry to REQ: no request issued, -> DONE with err=1; elements already done stand.
- REQ: mem_req=1; addr/be/wdata/we held stable until mem_gnt.
  - Store, gnt: last element -> DONE; else stay REQ, next element next cycle (back-to-back).
  - Load, gnt: -> WAIT, lane offset addr[1:0] latched.
- WAIT: on mem_rvalid, extract element at latched offset, zero-extend; register to vrf_wdata/vrf_widx with vrf_we=1 next cycle; last -> DONE, else REQ.
- mem_be: 8b 0001<<addr[1:0]; 16b 0011<<addr[1:0]; 32b 1111. Store data replicated into all lanes.
- DONE: done=1 one cycle, -> IDLE. start ignored outside IDLE; mem_rvalid ignored outside WAIT.

## Timing
- Reset: all outputs 0, state IDLE; nrst mid-operation aborts at that edge, no further vrf_we, no done.
- start at cycle T -> mem_req at T+1.
- Store, zero-wait grants: vl elements occupy T+1..T+vl; done at T+vl+1.
- Load: rvalid at t -> vrf_we at t+1 and, if elements remain, mem_req at t+1; final vrf_we coincides with done.
- One outstanding request max; mem_gnt and mem_rvalid in same cycle not possible by protocol.

## Structure
- Package v_lsu_pkg: op encodings VLE/VLSE/VSE/VSSE, sew enum, state enum.
- Sub-module v_lsu_lane (combinational): be generation, store replication, load extraction/zero-extension.

## Test plan
- VSE, vsew=010, vl=4, base=0x100, gnt tied 1 -> mem_addr 0x100,0x104,0x108,0x10C on 4 consecutive cycles, be=1111, done at T+5.
- VLE, vsew=000, vl=3, base=0x201, rdata=0xDDCCBBAA each -> vrf_wdata 0xBB,0xCC,0xDD at idx 0,1,2.
- VLSSE-style VLSE, vsew=001, stride=-4, base=0x40, vl=2 -> addresses 0x40,0x3C, be=0011.
- VSSE, vsew=001, base=0x3, vl=2 -> no mem_req, err=1 and done=1 at T+2.
- Store with mem_gnt held low 3 cycles -> mem_req/addr/wdata stable for all 3, advance on gnt.
- Load vl=4, nrst asserted after second vrf_we -> all outputs 0, no further vrf_we or done; later rvalid ignored.

Source files
------------

// File: rtl/v_lsu_pkg.sv
// Shared encodings for the vector load/store AGU: opcodes, element widths and FSM states.
package v_lsu_pkg;

   localparam logic [2:0] OpVle  = 3'b000;
   localparam logic [2:0] OpVlse = 3'b010;
   localparam logic [2:0] OpVse  = 3'b011;
   localparam logic [2:0] OpVsse = 3'b110;

   typedef enum logic [2:0] {
      Sew8  = 3'b000,
      Sew16 = 3'b001,
      Sew32 = 3'b010
   } sew_e;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StDone
   } state_e;

   // Natural alignment of an element at the given byte offset within a word.
   function automatic logic misaligned(input logic [1:0] off, input logic [2:0] sew);
      return ((sew == Sew16) && off[0]) || ((sew == Sew32) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/v_lsu_lane.sv
// Byte-lane steering: store byte enables and replication, load extraction with zero-extension.
module v_lsu_lane
   import v_lsu_pkg::*;
(
   input  logic [2:0]  sew_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] st_data_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] ld_word_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ld_elem_o
);

   logic [31:0] shifted;

   always_comb begin
      be_o      = 4'b0000;
      wdata_o   = 32'h0;
      ld_elem_o = 32'h0;
      shifted   = ld_word_i >> {ld_off_i, 3'b000};
      unique case (sew_i)
         Sew8: begin
            be_o      = 4'b0001 << off_i;
            wdata_o   = {4{st_data_i[7:0]}};
            ld_elem_o = {24'h0, shifted[7:0]};
         end
         Sew16: begin
            be_o      = 4'b0011 << off_i;
            wdata_o   = {2{st_data_i[15:0]}};
            ld_elem_o = {16'h0, shifted[15:0]};
         end
         Sew32: begin
            be_o      = 4'b1111;
            wdata_o   = st_data_i;
            ld_elem_o = shifted;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/v_lsu_agu.sv
// Vector load/store address generator: walks elements 0..vl-1, one outstanding memory request.
module v_lsu_agu
   import v_lsu_pkg::*;
#(
   parameter int unsigned MAX_VL = 32,
   parameter int unsigned IDX_W  = $clog2(MAX_VL) + 1
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             start,
   input  logic [2:0]       ld_store_op,
   input  logic [2:0]       vsew,
   input  logic [IDX_W-1:0] vl,
   input  logic [31:0]      base_addr,
   input  logic [31:0]      stride,
   input  logic [31:0]      vs3_rdata,
   output logic [IDX_W-1:0] elem_idx,
   output logic             mem_req,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [3:0]       mem_be,
   output logic [31:0]      mem_wdata,
   input  logic             mem_gnt,
   input  logic             mem_rvalid,
   input  logic [31:0]      mem_rdata,
   output logic             vrf_we,
   output logic [IDX_W-1:0] vrf_widx,
   output logic [31:0]      vrf_wdata,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_e           state_q;
   logic [2:0]       sew_q;
   logic             store_q;
   logic [IDX_W-1:0] vl_q, elem_idx_q, vrf_widx_q;
   logic [31:0]      addr_q, stride_q, vrf_wdata_q;
   logic [1:0]       off_q;
   logic             mem_req_q, err_q, vrf_we_q;

   logic [31:0] addr_d;
   logic        last;
   logic        legal_in, store_in, strided_in;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata, lane_elem;

   assign addr_d     = addr_q + stride_q;
   assign last       = (elem_idx_q == vl_q - IDX_W'(1));
   assign store_in   = (ld_store_op == OpVse) || (ld_store_op == OpVsse);
   assign strided_in = (ld_store_op == OpVlse) || (ld_store_op == OpVsse);
   assign legal_in   = ((ld_store_op == OpVle) || (ld_store_op == OpVlse) || store_in) &&
                       ((vsew == Sew8) || (vsew == Sew16) || (vsew == Sew32));

   v_lsu_lane u_lane (
      .sew_i     (sew_q),
      .off_i     (addr_q[1:0]),
      .st_data_i (vs3_rdata),
      .ld_off_i  (off_q),
      .ld_word_i (mem_rdata),
      .be_o      (lane_be),
      .wdata_o   (lane_wdata),
      .ld_elem_o (lane_elem)
   );

   // mem_req_q low while in StReq marks a misaligned element: no request, finish with err.
   always_ff @(posedge clk) begin
      if (nrst) begin
         state_q     <= StIdle;
         sew_q       <= 3'b000;
         store_q     <= 1'b0;
         vl_q        <= '0;
         elem_idx_q  <= '0;
         vrf_widx_q  <= '0;
         addr_q      <= 32'h0;
         stride_q    <= 32'h0;
         vrf_wdata_q <= 32'h0;
         off_q       <= 2'b00;
         mem_req_q   <= 1'b0;
         err_q       <= 1'b0;
         vrf_we_q    <= 1'b0;
      end else begin
         vrf_we_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  sew_q      <= vsew;
                  store_q    <= store_in;
                  vl_q       <= vl;
                  addr_q     <= base_addr;
                  stride_q   <= strided_in ? stride : (32'd1 << vsew[1:0]);
                  elem_idx_q <= '0;
                  if (!legal_in) begin
                     err_q   <= 1'b1;
                     state_q <= StDone;
                  end else if (vl == '0) begin
                     state_q <= StDone;
                  end else begin
                     mem_req_q <= !misaligned(base_addr[1:0], vsew);
                     state_q   <= StReq;
                  end
               end
            end
            StReq: begin
               if (!mem_req_q) begin
                  err_q   <= 1'b1;
                  state_q <= StDone;
               end else if (mem_gnt) begin
                  if (!store_q) begin
                     mem_req_q <= 1'b0;
                     off_q     <= addr_q[1:0];
                     state_q   <= StWait;
                  end else if (last) begin
                     mem_req_q <= 1'b0;
                     state_q   <= StDone;
                  end else begin
                     addr_q     <= addr_d;
                     elem_idx_q <= elem_idx_q + IDX_W'(1);
                     mem_req_q  <= !misaligned(addr_d[1:0], sew_q);
                  end
               end
            end
            StWait: begin
               if (mem_rvalid) begin
                  vrf_we_q    <= 1'b1;
                  vrf_widx_q  <= elem_idx_q;
                  vrf_wdata_q <= lane_elem;
                  if (last) begin
                     state_q <= StDone;
                  end else begin
                     addr_q     <= addr_d;
                     elem_idx_q <= elem_idx_q + IDX_W'(1);
                     mem_req_q  <= !misaligned(addr_d[1:0], sew_q);
                     state_q    <= StReq;
                  end
               end
            end
            StDone: begin
               err_q   <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign elem_idx  = elem_idx_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_req_q & store_q;
   assign mem_addr  = mem_req_q ? {addr_q[31:2], 2'b00} : 32'h0;
   assign mem_be    = mem_req_q ? lane_be : 4'b0000;
   assign mem_wdata = (mem_req_q & store_q) ? lane_wdata : 32'h0;
   assign vrf_we    = vrf_we_q;
   assign vrf_widx  = vrf_widx_q;
   assign vrf_wdata = vrf_wdata_q;
   assign busy      = (state_q == StReq) || (state_q == StWait);
   assign done      = (state_q == StDone);
   assign err       = err_q;

endmodule

// File: tb/tb_v_lsu_agu.sv
// Self-checking bench for v_lsu_agu: directed and randomized ops against an element-list model.
module tb_v_lsu_agu;

   localparam int MAX_VL = 32;
   localparam int IDX_W  = 6;

   logic             clk = 1'b0;
   logic             nrst, start, mem_gnt, mem_rvalid;
   logic [2:0]       ld_store_op, vsew;
   logic [IDX_W-1:0] vl;
   logic [31:0]      base_addr, stride, vs3_rdata, mem_rdata;
   logic [IDX_W-1:0] elem_idx, vrf_widx;
   logic             mem_req, mem_we, vrf_we, busy, done, err;
   logic [31:0]      mem_addr, mem_wdata, vrf_wdata;
   logic [3:0]       mem_be;

   always #5 clk = ~clk;

   v_lsu_agu #(.MAX_VL(MAX_VL), .IDX_W(IDX_W)) dut (
      .clk(clk), .nrst(nrst), .start(start), .ld_store_op(ld_store_op), .vsew(vsew), .vl(vl),
      .base_addr(base_addr), .stride(stride), .vs3_rdata(vs3_rdata), .elem_idx(elem_idx),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .vrf_we(vrf_we), .vrf_widx(vrf_widx), .vrf_wdata(vrf_wdata), .busy(busy), .done(done),
      .err(err)
   );

   int checks = 0;
   int failures = 0;

   logic [31:0] sd[MAX_VL];
   logic [31:0] rword[MAX_VL];
   logic [31:0] e_addr[$];
   logic [31:0] e_wd[$];
   logic [31:0] e_vd[$];
   logic [3:0]  e_be[$];
   bit          e_err, e_store;
   int          e_n;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Element list straight from the rules: address i = base + i*step, stop at first misaligned.
   task automatic build(input logic [2:0] op, input logic [2:0] sew, input int n,
                        input logic [31:0] base, input logic [31:0] strd);
      logic [31:0] step, a;
      int          off;
      longint      mask;
      e_addr.delete(); e_wd.delete(); e_vd.delete(); e_be.delete();
      e_err   = 0;
      e_n     = 0;
      e_store = (op == 3'b011) || (op == 3'b110);
      if (!(op inside {3'b000, 3'b010, 3'b011, 3'b110}) || sew > 3'd2) begin
         e_err = 1;
         return;
      end
      step = (op == 3'b010 || op == 3'b110) ? strd : (32'd1 << sew);
      mask = (longint'(1) << (8 << sew)) - 1;
      for (int i = 0; i < n; i++) begin
         a   = base + step * 32'(i);
         off = int'(a % 4);
         if ((sew == 3'd1 && a % 2 != 0) || (sew == 3'd2 && off != 0)) begin
            e_err = 1;
            break;
         end
         e_addr.push_back(a - 32'(off));
         e_be.push_back(sew == 3'd0 ? 4'(1 << off) : sew == 3'd1 ? 4'(3 << off) : 4'hF);
         e_wd.push_back(sew == 3'd0 ? sd[i][7:0] * 32'h0101_0101 :
                        sew == 3'd1 ? sd[i][15:0] * 32'h0001_0001 : sd[i]);
         e_vd.push_back(32'((longint'(rword[i]) >> (8 * off)) & mask));
      end
      e_n = e_addr.size();
   endtask

   // gmode: 0 grant at once, 1 random grant, 2 hold grant low 3 cycles per request.
   task automatic run(input string nm, input logic [2:0] op, input logic [2:0] sew, input int n,
                      input logic [31:0] base, input logic [31:0] strd, input int gmode,
                      input bit fixw, input logic [31:0] fw, output int done_cyc,
                      output int first_req);
      int  got_req, got_wr, nwr, rv_cnt, low_cnt;
      bit  hold, prev_rv, this_rv, finished, g;
      logic [31:0] h_addr, h_wd;
      logic [3:0]  h_be;
      for (int i = 0; i < MAX_VL; i++) begin
         sd[i]    = $urandom;
         rword[i] = fixw ? fw : $urandom;
      end
      build(op, sew, n, base, strd);
      nwr = e_store ? 0 : e_n;
      ld_store_op = op; vsew = sew; vl = IDX_W'(n); base_addr = base; stride = strd;
      start = 1'b1;
      got_req = 0; got_wr = 0; rv_cnt = -1; low_cnt = 0;
      hold = 0; prev_rv = 0; finished = 0; done_cyc = -1; first_req = -1;
      h_addr = 0; h_wd = 0; h_be = 0;
      for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
         @(posedge clk);
         #1;
         start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
         this_rv = 0;
         vs3_rdata = sd[elem_idx[4:0]];
         #1;
         if (prev_rv) begin
            chk({nm, ":vrf_we_after_rvalid"}, 32'(vrf_we), 32'd1);
            chk({nm, ":req_after_rvalid"}, 32'(mem_req), 32'(got_req < e_n));
         end
         if (vrf_we) begin
            if (got_wr < nwr) begin
               chk({nm, ":vrf_widx"}, 32'(vrf_widx), 32'(got_wr));
               chk({nm, ":vrf_wdata"}, vrf_wdata, e_vd[got_wr]);
            end else chk({nm, ":extra_vrf_we"}, 32'd1, 32'd0);
            got_wr++;
         end
         if (rv_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rword[got_req - 1];
            this_rv    = 1;
            rv_cnt     = -1;
         end else if (rv_cnt > 0) rv_cnt--;
         if (hold && !mem_req) chk({nm, ":req_dropped"}, 32'd0, 32'd1);
         if (mem_req) begin
            if (first_req < 0) first_req = cyc;
            if (hold) begin
               chk({nm, ":hold_addr"}, mem_addr, h_addr);
               chk({nm, ":hold_be"}, 32'(mem_be), 32'(h_be));
               chk({nm, ":hold_wdata"}, mem_wdata, h_wd);
            end
            g = (gmode == 0) ? 1'b1 : (gmode == 1) ? ($urandom % 3 != 0) : (low_cnt >= 3);
            if (g) begin
               if (got_req < e_n) begin
                  chk({nm, ":addr"}, mem_addr, e_addr[got_req]);
                  chk({nm, ":be"}, 32'(mem_be), 32'(e_be[got_req]));
                  chk({nm, ":we"}, 32'(mem_we), 32'(e_store));
                  if (e_store) chk({nm, ":wdata"}, mem_wdata, e_wd[got_req]);
               end else chk({nm, ":extra_req"}, 32'd1, 32'd0);
               got_req++;
               if (!e_store) rv_cnt = int'($urandom_range(0, 2));
               low_cnt = 0;
               hold    = 0;
            end else begin
               low_cnt++;
               hold   = 1;
               h_addr = mem_addr; h_be = mem_be; h_wd = mem_wdata;
            end
            mem_gnt = g;
         end else hold = 0;
         if (done) begin
            chk({nm, ":err"}, 32'(err), 32'(e_err));
            chk({nm, ":req_count"}, 32'(got_req), 32'(e_n));
            chk({nm, ":vrf_count"}, 32'(got_wr), 32'(nwr));
            done_cyc = cyc;
            finished = 1;
         end
         prev_rv = this_rv;
      end
      if (!finished) chk({nm, ":timeout"}, 32'd0, 32'd1);
      @(posedge clk);
      #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk({nm, ":done_pulse"}, 32'({done, err, busy}), 32'd0);
   endtask

   initial begin
      int dc, fr, nwe;
      bit rv_next, seen;
      logic [2:0]  rop, rsew;
      logic [31:0] rbase, rstr;
      logic [2:0]  ops[5];
      ops = '{3'b000, 3'b010, 3'b011, 3'b110, 3'b101};
      nrst = 1'b1; start = 1'b0; ld_store_op = 3'b000; vsew = 3'b000; vl = '0;
      base_addr = 0; stride = 0; vs3_rdata = 0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctrl", 32'({mem_req, mem_we, vrf_we, busy, done, err}), 32'd0);
      chk("rst_data", mem_addr | mem_wdata | vrf_wdata | 32'(mem_be), 32'd0);
      chk("rst_idx", 32'({elem_idx, vrf_widx}), 32'd0);
      nrst = 1'b0;

      run("vse_unit", 3'b011, 3'd2, 4, 32'h100, 32'h0, 0, 0, 0, dc, fr);
      chk("vse_first_req_cycle", 32'(fr), 32'd1);
      chk("vse_done_cycle", 32'(dc), 32'd5);
      run("vle_byte", 3'b000, 3'd0, 3, 32'h201, 32'h0, 1, 1, 32'hDDCC_BBAA, dc, fr);
      run("vlse_neg", 3'b010, 3'd1, 2, 32'h40, 32'hFFFF_FFFC, 1, 0, 0, dc, fr);
      run("vsse_misal", 3'b110, 3'd1, 2, 32'h3, 32'h2, 0, 0, 0, dc, fr);
      chk("vsse_misal_done_cycle", 32'(dc), 32'd2);
      run("vse_stall", 3'b011, 3'd0, 3, 32'h51, 32'h0, 2, 0, 0, dc, fr);
      run("vl_zero", 3'b000, 3'd2, 0, 32'h0, 32'h0, 0, 0, 0, dc, fr);
      chk("vl_zero_done_cycle", 32'(dc), 32'd1);
      run("bad_sew", 3'b011, 3'd3, 2, 32'h0, 32'h0, 0, 0, 0, dc, fr);
      run("mid_misal", 3'b010, 3'd2, 3, 32'h1000, 32'h6, 1, 0, 0, dc, fr);

      for (int t = 0; t < 12; t++) begin
         rop   = ops[($urandom % 8 == 0) ? 4 : $urandom % 4];
         rsew  = ($urandom % 8 == 0) ? 3'd3 : 3'($urandom % 3);
         rbase = $urandom;
         if ($urandom % 4 != 0) rbase = rbase & ~((32'd1 << rsew[1:0]) - 1);
         rstr  = 32'(int'($urandom_range(0, 16)) - 8);
         if ($urandom % 4 != 0) rstr = rstr << rsew[1:0];
         run("rand", rop, rsew, int'($urandom_range(0, 8)), rbase, rstr, 1, 0, 0, dc, fr);
      end

      // Reset in the middle of a load, after the second element is written back.
      ld_store_op = 3'b000; vsew = 3'd2; vl = 6'd4; base_addr = 32'h300; stride = 0;
      start = 1'b1; nwe = 0; rv_next = 0;
      for (int c = 0; c < 60 && nwe < 2; c++) begin
         @(posedge clk);
         #1;
         start = 1'b0; mem_gnt = 1'b0; mem_rvalid = rv_next; mem_rdata = $urandom; rv_next = 0;
         #1;
         if (vrf_we) nwe++;
         if (mem_req && nwe < 2) begin
            mem_gnt = 1'b1;
            rv_next = 1;
         end
      end
      chk("abort_pre_writes", 32'(nwe), 32'd2);
      nrst = 1'b1;
      @(posedge clk);
      #1;
      nrst = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("abort_ctrl", 32'({mem_req, mem_we, vrf_we, busy, done, err}), 32'd0);
      chk("abort_data", mem_addr | mem_wdata | vrf_wdata | 32'(mem_be), 32'd0);
      chk("abort_idx", 32'({elem_idx, vrf_widx}), 32'd0);
      mem_rvalid = 1'b1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         mem_rvalid = 1'b0;
         if (vrf_we || done || mem_req) seen = 1;
      end
      chk("abort_quiet", 32'(seen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
